// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl
//   Read-side controller for an HD44780-style character LCD bus. Runs timed
//   read cycles (RW=1) to fetch either the busy flag / address counter
//   (RS=0) or a DDRAM/CGRAM byte (RS=1). In poll mode it repeats busy-flag
//   reads until the LCD reports ready or a timeout expires, so the writer
//   can replace its fixed delays with a status poll.
//
// Ports
//   clk        in   system clock (50 MHz nominal)
//   reset      in   asynchronous, active-low reset
//   req        in   start a read; accepted only while ready=1
//   req_rs     in   RS for the read: 0 = busy flag/address, 1 = data RAM
//   req_poll   in   with req_rs=0, repeat busy-flag reads until BF=0/timeout
//   ready      out  controller idle and able to accept req
//   done       out  one-cycle pulse; rd_data/busy_flag/timeout valid with it
//   rd_data    out  last byte published at done, held until the next done
//   busy_flag  out  rd_data[7] when the last read used RS=0, else 0
//   timeout    out  poll gave up with BF still set; held like rd_data
//   bus_own    out  reader owns E/RS/RW; the writer must stay off the bus
//   lcd_e      out  LCD enable (registered)
//   lcd_rs     out  LCD register select
//   lcd_rw     out  LCD read/write, 1 while the reader owns the bus
//   lcd_db_in  in   LCD data bus as seen by the reader (never driven here)

module lcd_read_ctrl #(
  parameter int T_AS_CYC    = 3,
  parameter int T_EH_CYC    = 13,
  parameter int T_AH_CYC    = 1,
  parameter int T_CYC_MIN   = 25,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       ready,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic       timeout,
  output logic       bus_own,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [7:0] lcd_db_in
);

  // Recovery stretches the E-low time so rise-to-rise meets T_CYC_MIN.
  localparam int T_REC_RAW = T_CYC_MIN - T_EH_CYC - T_AH_CYC;
  localparam int T_REC     = (T_REC_RAW < 1) ? 1 : T_REC_RAW;

  localparam int MAX_AE  = (T_AS_CYC > T_EH_CYC) ? T_AS_CYC : T_EH_CYC;
  localparam int MAX_HR  = (T_AH_CYC > T_REC) ? T_AH_CYC : T_REC;
  localparam int MAX_DUR = (MAX_AE > MAX_HR) ? MAX_AE : MAX_HR;
  // The phase timer holds duration-1 down to 0.
  localparam int TMR_W   = (MAX_DUR < 2) ? 1 : $clog2(MAX_DUR);
  localparam int TC_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TMR_W-1:0] AS_LD  = TMR_W'(T_AS_CYC - 1);
  localparam logic [TMR_W-1:0] EH_LD  = TMR_W'(T_EH_CYC - 1);
  localparam logic [TMR_W-1:0] AH_LD  = TMR_W'(T_AH_CYC - 1);
  localparam logic [TMR_W-1:0] REC_LD = TMR_W'(T_REC - 1);
  localparam logic [TC_W-1:0]  TC_SAT = TC_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    EHIGH   = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [TMR_W-1:0]  tmr, tmr_n;
  logic [TC_W-1:0]   tcount;
  logic              rs_q, poll_q;
  logic [7:0]        cap_q;

  logic              accept;
  logic              publish;
  logic              capture;
  logic              tc_expired;
  logic              rs_n;
  logic              own_n;

  assign ready      = (state == IDLE);
  assign tc_expired = (tcount >= TC_SAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = (tmr != '0) ? tmr - TMR_W'(1) : tmr;
    accept  = 1'b0;
    publish = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_n = SETUP;
          tmr_n   = AS_LD;
        end
      end
      SETUP: begin
        if (tmr == '0) begin
          state_n = EHIGH;
          tmr_n   = EH_LD;
        end
      end
      EHIGH: begin
        // Last E-high cycle: the LCD has had the full access time.
        if (tmr == '0) begin
          capture = 1'b1;
          state_n = HOLD;
          tmr_n   = AH_LD;
        end
      end
      HOLD: begin
        if (tmr == '0) begin
          state_n = RECOVER;
          tmr_n   = REC_LD;
        end
      end
      RECOVER: begin
        if (tmr == '0) begin
          if (!poll_q || !cap_q[7] || tc_expired) begin
            publish = 1'b1;
            state_n = DONE;
          end else begin
            state_n = SETUP;
            tmr_n   = AS_LD;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase

    // RS must already be valid in the first SETUP cycle, so bypass rs_q on accept.
    rs_n  = accept ? req_rs : rs_q;
    own_n = (state_n == SETUP) || (state_n == EHIGH) ||
            (state_n == HOLD)  || (state_n == RECOVER);
  end

  // Bus and result registers: driven from the next state so every output is
  // a flop and E cannot glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      tcount    <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      bus_own   <= 1'b0;
      done      <= 1'b0;
      rd_data   <= 8'h00;
      busy_flag <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (accept) begin
        rs_q   <= req_rs;
        poll_q <= req_poll & ~req_rs;
        tcount <= '0;
      end else if (!tc_expired) begin
        tcount <= tcount + TC_W'(1);
      end
      lcd_e   <= (state_n == EHIGH);
      lcd_rs  <= own_n & rs_n;
      lcd_rw  <= own_n;
      bus_own <= own_n;
      done    <= (state_n == DONE);
      if (publish) begin
        rd_data   <= cap_q;
        busy_flag <= cap_q[7] & ~rs_q;
        // Reaching DONE with BF still set in poll mode can only mean expiry.
        timeout   <= poll_q & cap_q[7];
      end
    end
  end

  // Raw sample of the bus; only meaningful after a read, so no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_q <= lcd_db_in;
    end
  end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
module tb_lcd_read_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic       req_rs;
  logic       req_poll;
  logic       ready;
  logic       done;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic       timeout;
  logic       bus_own;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db_in;

  int n_vec;
  int n_err;

  // Short timeout so the expiry case stays fast; all other timing is default.
  lcd_read_ctrl #(
    .T_AS_CYC    (3),
    .T_EH_CYC    (13),
    .T_AH_CYC    (1),
    .T_CYC_MIN   (25),
    .TIMEOUT_CYC (200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rs    (req_rs),
    .req_poll  (req_poll),
    .ready     (ready),
    .done      (done),
    .rd_data   (rd_data),
    .busy_flag (busy_flag),
    .timeout   (timeout),
    .bus_own   (bus_own),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db_in (lcd_db_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; drive and sample there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and watches the bus until done (bounded).
  // Cycle 1 is the first sample after the accepting edge.
  task automatic run_txn(input logic rs, input logic poll, input int busy_reads,
                         input logic [7:0] bf_val, input logic [7:0] fin_val,
                         input int poke_req_at, input bit hold_req,
                         output int done_cyc, output int pulses, output int e_hi,
                         output int rise1, output int rise2, output bit bus_ok);
    int  cyc;
    bit  prev_e;
    bit  fin;
    done_cyc  = -1;
    pulses    = 0;
    e_hi      = 0;
    rise1     = -1;
    rise2     = -1;
    bus_ok    = 1'b1;
    prev_e    = 1'b0;
    fin       = 1'b0;
    req_rs    = rs;
    req_poll  = poll;
    lcd_db_in = (busy_reads > 0) ? bf_val : fin_val;
    req       = 1'b1;
    tick();
    if (!hold_req) req = 1'b0;
    cyc = 1;
    while (!fin && cyc <= 400) begin
      if (lcd_e && !prev_e) begin
        pulses++;
        if (pulses == 1) rise1 = cyc;
        if (pulses == 2) rise2 = cyc;
        lcd_db_in = (pulses <= busy_reads) ? bf_val : fin_val;
      end
      prev_e = lcd_e;
      if (lcd_e) e_hi++;
      if (bus_own && (lcd_rs !== rs || lcd_rw !== 1'b1)) bus_ok = 1'b0;
      if (!bus_own && lcd_e) bus_ok = 1'b0;
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        if (poke_req_at != 0 && cyc == poke_req_at) req = 1'b1;
        else if (!hold_req) req = 1'b0;
        tick();
        cyc++;
      end
    end
  endtask

  initial begin
    int  dc, np, eh, r1, r2;
    bit  ok;
    bit  seen;
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    req       = 1'b0;
    req_rs    = 1'b0;
    req_poll  = 1'b0;
    lcd_db_in = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_e",       lcd_e,     1'b0);
    chk("rst_own",     bus_own,   1'b0);
    chk("rst_rw",      lcd_rw,    1'b0);
    chk("rst_rdata",   rd_data,   8'h00);
    chk("rst_done",    done,      1'b0);
    reset = 1'b1;
    tick();
    chk("rst_ready",   ready,     1'b1);

    // Single busy-flag read
    run_txn(1'b0, 1'b0, 0, 8'h00, 8'hA5, 0, 1'b0, dc, np, eh, r1, r2, ok);
    chk("bf_done_cyc", dc,        29);
    chk("bf_rdata",    rd_data,   8'hA5);
    chk("bf_busy",     busy_flag, 1'b1);
    chk("bf_timeout",  timeout,   1'b0);
    chk("bf_e_high",   eh,        13);
    chk("bf_pulses",   np,        1);
    chk("bf_rise",     r1,        4);
    chk("bf_bus",      ok,        1'b1);
    chk("bf_ready_dn", ready,     1'b0);
    tick();
    chk("bf_done_1cy", done,      1'b0);
    chk("bf_ready",    ready,     1'b1);

    // Data read: RS=1 on the bus, no busy flag reported
    run_txn(1'b1, 1'b0, 0, 8'h00, 8'h3C, 0, 1'b0, dc, np, eh, r1, r2, ok);
    chk("dr_done_cyc", dc,        29);
    chk("dr_rdata",    rd_data,   8'h3C);
    chk("dr_busy",     busy_flag, 1'b0);
    chk("dr_timeout",  timeout,   1'b0);
    chk("dr_bus_rs",   ok,        1'b1);
    tick();

    // Poll requested with RS=1 and bit7 set: still a single read
    run_txn(1'b1, 1'b1, 0, 8'h00, 8'hBC, 0, 1'b0, dc, np, eh, r1, r2, ok);
    chk("dp_done_cyc", dc,        29);
    chk("dp_pulses",   np,        1);
    chk("dp_rdata",    rd_data,   8'hBC);
    chk("dp_busy",     busy_flag, 1'b0);
    tick();

    // Poll: BF=1 for three reads, then ready
    run_txn(1'b0, 1'b1, 3, 8'h8B, 8'h07, 0, 1'b0, dc, np, eh, r1, r2, ok);
    chk("pl_done_cyc", dc,        113);
    chk("pl_pulses",   np,        4);
    chk("pl_period",   r2 - r1,   28);
    chk("pl_rdata",    rd_data,   8'h07);
    chk("pl_busy",     busy_flag, 1'b0);
    chk("pl_timeout",  timeout,   1'b0);
    chk("pl_bus",      ok,        1'b1);
    tick();

    // Poll with BF stuck: times out after the read that ends past 200 cycles
    run_txn(1'b0, 1'b1, 1000, 8'h8B, 8'h00, 0, 1'b0, dc, np, eh, r1, r2, ok);
    chk("to_done_cyc", dc,        225);
    chk("to_pulses",   np,        8);
    chk("to_timeout",  timeout,   1'b1);
    chk("to_busy",     busy_flag, 1'b1);
    chk("to_rdata",    rd_data,   8'h8B);
    tick();

    // Request pulsed mid-transaction is ignored and not queued
    run_txn(1'b0, 1'b0, 0, 8'h00, 8'h12, 6, 1'b0, dc, np, eh, r1, r2, ok);
    chk("ig_done_cyc", dc,        29);
    chk("ig_pulses",   np,        1);
    chk("ig_timeout",  timeout,   1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_own || lcd_e) seen = 1'b1;
    end
    chk("ig_no_second", seen,     1'b0);

    // Back-to-back: req held through DONE starts SETUP two cycles later
    run_txn(1'b0, 1'b0, 0, 8'h00, 8'h55, 0, 1'b1, dc, np, eh, r1, r2, ok);
    chk("bb_done_cyc", dc,        29);
    tick();
    chk("bb_idle_rdy", ready,     1'b1);
    chk("bb_idle_own", bus_own,   1'b0);
    tick();
    req = 1'b0;
    chk("bb_setup_own", bus_own,  1'b1);
    chk("bb_setup_rw",  lcd_rw,   1'b1);
    chk("bb_setup_e",   lcd_e,    1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("bb_second_done", seen,   1'b1);
    tick();

    // Reset asserted while E is high
    req_rs    = 1'b1;
    req_poll  = 1'b0;
    lcd_db_in = 8'hC3;
    req       = 1'b1;
    tick();
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (lcd_e) seen = 1'b1;
    end
    chk("mr_e_rose", seen, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mr_e",       lcd_e,     1'b0);
    chk("mr_own",     bus_own,   1'b0);
    chk("mr_rs",      lcd_rs,    1'b0);
    chk("mr_rw",      lcd_rw,    1'b0);
    chk("mr_rdata",   rd_data,   8'h00);
    chk("mr_busy",    busy_flag, 1'b0);
    chk("mr_done",    done,      1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_ready",   ready,     1'b1);
    chk("mr_own_idle", bus_own,  1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
